// File: rtl/cache_mem_arbiter.sv
// ============================================================================
//  Module   : cache_mem_arbiter
//  Purpose  : Shares one multi-cycle memory between I-cache fills, D-cache
//             fills and D-cache write-throughs; streams fill words and tags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_data,
    input  logic        mem_vld,
    output logic        fill_i_we,
    output logic        fill_d_we,
    output logic [2:0]  fill_word,
    output logic [15:0] fill_data,
    output logic        i_tag_we,
    output logic        d_tag_we,
    output logic        i_done,
    output logic        d_done,
    output logic        busy
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_IFILL   = 3'd1;
    localparam logic [2:0] c_DFILL   = 3'd2;
    localparam logic [2:0] c_DWRITE  = 3'd3;
    localparam logic [2:0] c_RELEASE = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [3:0]  iss_q, iss_d;
    logic [2:0]  rcv_q, rcv_d;
    logic        last_grant_q, last_grant_d;   // 0 = I-cache, 1 = D-cache
    logic        grant_d_side;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        iss_d        = iss_q;
        rcv_d        = rcv_q;
        last_grant_d = last_grant_q;
        grant_d_side = 1'b0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'h0000;
        mem_wdata    = 16'h0000;
        fill_i_we    = 1'b0;
        fill_d_we    = 1'b0;
        fill_word    = 3'd0;
        fill_data    = 16'h0000;
        i_tag_we     = 1'b0;
        d_tag_we     = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (i_req || d_req) begin
                    // On a tie the side that was not served last wins.
                    grant_d_side = d_req && (!i_req || !last_grant_q);
                    state_d      = grant_d_side ? (d_wr ? c_DWRITE : c_DFILL) : c_IFILL;
                    addr_d       = grant_d_side ? d_addr : i_addr;
                    wdata_d      = d_wdata;
                    last_grant_d = grant_d_side;
                    iss_d        = 4'd0;
                    rcv_d        = 3'd0;
                end
            end

            c_IFILL, c_DFILL: begin
                if (!iss_q[3]) begin
                    mem_en   = 1'b1;
                    mem_addr = {addr_q[15:4], iss_q[2:0], 1'b0};
                    iss_d    = iss_q + 4'd1;
                end
                // Responses are counted, never timed, so any latency works.
                if (mem_vld) begin
                    fill_i_we = (state_q == c_IFILL);
                    fill_d_we = (state_q == c_DFILL);
                    fill_word = rcv_q;
                    fill_data = mem_data;
                    rcv_d     = rcv_q + 3'd1;
                    if (rcv_q == 3'd7) begin
                        i_tag_we = (state_q == c_IFILL);
                        d_tag_we = (state_q == c_DFILL);
                        i_done   = (state_q == c_IFILL);
                        d_done   = (state_q == c_DFILL);
                        state_d  = c_RELEASE;
                    end
                end
            end

            c_DWRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                d_done    = 1'b1;
                state_d   = c_RELEASE;
            end

            c_RELEASE: state_d = c_IDLE;

            default: state_d = c_IDLE;
        endcase
    end

    assign busy = (state_q != c_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= c_IDLE;
            addr_q       <= 16'h0000;
            wdata_q      <= 16'h0000;
            iss_q        <= 4'd0;
            rcv_q        <= 3'd0;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            iss_q        <= iss_d;
            rcv_q        <= rcv_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// ============================================================================
//  Module   : tb_cache_mem_arbiter
//  Purpose  : Directed self-checking bench for cache_mem_arbiter with a
//             latency-configurable memory model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_mem_arbiter;

    localparam int MEM_LATENCY = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = 16'h0000;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = 16'h0000;
    logic [15:0] d_wdata = 16'h0000;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_data = 16'h0000;
    logic        mem_vld = 1'b0;
    logic        fill_i_we, fill_d_we;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        i_tag_we, d_tag_we, i_done, d_done, busy;

    int n_checks = 0;
    int n_errors = 0;

    cache_mem_arbiter u_dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_data  (mem_data),
        .mem_vld   (mem_vld),
        .fill_i_we (fill_i_we),
        .fill_d_we (fill_d_we),
        .fill_word (fill_word),
        .fill_data (fill_data),
        .i_tag_we  (i_tag_we),
        .d_tag_we  (d_tag_we),
        .i_done    (i_done),
        .d_done    (d_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Memory model: read data is a fixed scramble of the address.
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5AC3;
    endfunction

    int          cyc = 0;
    int          mem_lat = MEM_LATENCY;
    bit          gap_en = 1'b0;
    logic [15:0] q_addr[$];
    int          q_rdy[$];
    int          q_tmp;

    always begin
        @(negedge clk);
        if (mem_en && !mem_wr) begin
            q_addr.push_back(mem_addr);
            q_rdy.push_back(cyc + mem_lat);
        end
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (q_addr.size() > 0 && q_rdy[0] <= cyc && !(gap_en && (cyc % 3 == 0))) begin
            mem_vld  = 1'b1;
            mem_data = mem_fn(q_addr.pop_front());
            q_tmp    = q_rdy.pop_front();
        end else begin
            mem_vld  = 1'b0;
            mem_data = 16'hDEAD;
        end
    end

    initial begin
        #40000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at the start of the granted cycle; returns at the negedge of done.
    task automatic observe_fill(input bit is_d, input logic [15:0] base, input int exp_done_k);
        int          iss;
        int          rcv;
        int          done_k;
        logic        we, tag, done, other;
        logic [15:0] ea;
        iss = 0;
        rcv = 0;
        done_k = -1;
        for (int k = 0; k < 40 && done_k < 0; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            check_eq("fill_mem_en", mem_en, (k < 8));
            if (mem_en) begin
                check_eq("fill_addr", mem_addr, base | 16'(iss * 2));
                check_eq("fill_rd", mem_wr, 0);
                iss = iss + 1;
            end
            we    = is_d ? fill_d_we : fill_i_we;
            tag   = is_d ? d_tag_we : i_tag_we;
            done  = is_d ? d_done : i_done;
            other = is_d ? (fill_i_we | i_tag_we | i_done) : (fill_d_we | d_tag_we | d_done);
            check_eq("other_side", other, 0);
            check_eq("fill_we_vs_vld", we, mem_vld);
            if (we) begin
                ea = base | 16'(rcv * 2);
                check_eq("fill_word", fill_word, rcv);
                check_eq("fill_data", fill_data, mem_fn(ea));
                rcv = rcv + 1;
            end
            check_eq("tag_we", tag, (we && rcv == 8));
            check_eq("done", done, (we && rcv == 8));
            if (done) done_k = k;
        end
        check_eq("issued", iss, 8);
        check_eq("received", rcv, 8);
        if (exp_done_k >= 0) check_eq("done_cycle", done_k, exp_done_k);
        else                 check_eq("done_seen", (done_k >= 0), 1);
    endtask

    // RELEASE then IDLE; optionally drop requests at the RELEASE cycle.
    task automatic release_idle(input bit drop);
        tick();
        if (drop) begin
            i_req = 1'b0;
            d_req = 1'b0;
        end
        @(negedge clk);
        check_eq("release_busy", busy, 1);
        check_eq("release_quiet", {mem_en, fill_i_we, fill_d_we, i_done, d_done}, 0);
        tick();
        @(negedge clk);
        check_eq("idle_busy", busy, 0);
    endtask

    task automatic do_fill(input bit is_d, input logic [15:0] addr, input int lat, input bit gaps);
        mem_lat = lat;
        gap_en  = gaps;
        if (is_d) begin
            d_req  = 1'b1;
            d_wr   = 1'b0;
            d_addr = addr;
        end else begin
            i_req  = 1'b1;
            i_addr = addr;
        end
        tick();
        i_addr = 16'hFFFF;
        d_addr = 16'hFFFF;
        observe_fill(is_d, addr & 16'hFFF0, gaps ? -1 : lat + 7);
        release_idle(1'b1);
    endtask

    initial begin
        int bad;
        int vlds;

        // Reset with a pending request.
        rst   = 1'b0;
        i_req = 1'b1;
        i_addr = 16'h1236;
        tick();
        tick();
        @(negedge clk);
        check_eq("rst_ctrl", {mem_en, mem_wr, fill_i_we, fill_d_we, i_tag_we, d_tag_we, i_done, d_done, busy}, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_fill", {fill_word, fill_data}, 0);
        rst   = 1'b1;
        i_req = 1'b0;
        tick();

        // Tie: both held; D first (last grant resets to I), then I, then D.
        i_req  = 1'b1;
        i_addr = 16'h2220;
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_addr = 16'h3330;
        mem_lat = MEM_LATENCY;
        tick();
        observe_fill(1'b1, 16'h3330, MEM_LATENCY + 7);
        release_idle(1'b0);
        tick();
        observe_fill(1'b0, 16'h2220, MEM_LATENCY + 7);
        release_idle(1'b0);
        tick();
        observe_fill(1'b1, 16'h3330, MEM_LATENCY + 7);
        release_idle(1'b1);

        // I-fill with default latency.
        do_fill(1'b0, 16'h1236, MEM_LATENCY, 1'b0);

        // Write-through; inputs change after the grant to prove latching.
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 16'h0A0C;
        d_wdata = 16'hBEEF;
        tick();
        d_addr  = 16'h0000;
        d_wdata = 16'h0000;
        @(negedge clk);
        check_eq("wr_ctrl", {mem_en, mem_wr, d_done, i_done, d_tag_we}, 5'b11100);
        check_eq("wr_addr", mem_addr, 16'h0A0C);
        check_eq("wr_data", mem_wdata, 16'hBEEF);
        release_idle(1'b1);
        d_wr = 1'b0;

        // Reset in the cycle carrying the 3rd response of a D-fill.
        mem_lat = MEM_LATENCY;
        gap_en  = 1'b0;
        d_req   = 1'b1;
        d_addr  = 16'h4567;
        tick();
        for (int k = 0; k < 6; k++) tick();
        rst   = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_pre", {mem_vld, fill_d_we, fill_word}, 5'b11010);
        bad  = 0;
        vlds = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (j == 1) rst = 1'b1;
            @(negedge clk);
            bad  = bad + int'(fill_d_we | d_tag_we | d_done | mem_en | busy | fill_i_we);
            vlds = vlds + int'(mem_vld);
        end
        check_eq("rst_mid_quiet", bad, 0);
        check_eq("rst_mid_inflight", vlds, 4);
        do_fill(1'b0, 16'h0104, MEM_LATENCY, 1'b0);

        // Latency sweep and gapped responses.
        do_fill(1'b0, 16'h7778, 1, 1'b0);
        do_fill(1'b1, 16'h9ABC, 7, 1'b1);
        do_fill(1'b0, 16'h5550, 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Sequencer and arbiter for the single shared multi-cycle memory behind the I-cache and D-cache. It accepts I-cache fill requests, D-cache fill requests and D-cache write-through requests, and grants one at a time. For fills it issues eight pipelined word reads and streams the returned words into the requesting cache's data array, then writes the tag. It sits between the cache controller's miss/write logic and the multi-cycle memory, and replaces the per-cache fill FSM.

## Interface
- MEM_LATENCY, 4: memory read latency in cycles. Used only by the bench; the arbiter counts `mem_vld` and does not assume a latency.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low
- i_req  in  1  I-cache fill request; held until `i_done`
- i_addr  in  16  I-cache miss address
- d_req  in  1  D-cache request; held until `d_done`
- d_wr  in  1  qualifies `d_req`: 1 = write-through, 0 = fill
- d_addr  in  16  D-cache address
- d_wdata  in  16  write-through data
- mem_en  out  1  memory request strobe, one request per cycle
- mem_wr  out  1  memory write enable
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_data  in  16  memory read data
- mem_vld  in  1  `mem_data` valid
- fill_i_we  out  1  write `fill_data` into I-cache word `fill_word`
- fill_d_we  out  1  write `fill_data` into D-cache word `fill_word`
- fill_word  out  3  word index within the block
- fill_data  out  16  word being filled
- i_tag_we  out  1  write I-cache tag/valid for the latched block
- d_tag_we  out  1  write D-cache tag/valid for the latched block
- i_done  out  1  one-cycle completion pulse for the I-cache request
- d_done  out  1  one-cycle completion pulse for the D-cache request
- busy  out  1  state != IDLE

## Operation
- States: IDLE, IFILL, DFILL, DWRITE, RELEASE.
- **IDLE.** Requests are sampled only in IDLE.
  - Candidates are `i_req` and `d_req`.
  - If both are pending, grant the one not granted last (`last_grant` bit; reset value = I, so D wins the first tie).
  - If only one is pending, grant it.
  - A D grant goes to DWRITE if `d_wr`=1, else to DFILL.
  - On grant, latch `base` = addr & 16'hFFF0, latch `d_wdata`, and update `last_grant`.
- **IFILL / DFILL.**
  - Issue counter `iss` (0..8): while `iss`<8, drive `mem_en`=1, `mem_wr`=0, `mem_addr` = `base` | {iss,1'b0}, and increment `iss`.
  - Receive counter `rcv` (0..7): on `mem_vld`, assert `fill_*_we` for the granted cache, `fill_word`=`rcv`, `fill_data`=`mem_data`, and increment `rcv`.
  - On `mem_vld` with `rcv`==7, in the same cycle: assert `*_tag_we` and `*_done`, then go to RELEASE.
- **DWRITE.** One cycle only.
  - Drive `mem_en`=1, `mem_wr`=1, `mem_addr` = latched full `d_addr`, `mem_wdata` = latched data, and assert `d_done`.
  - Go to RELEASE.
- **RELEASE.** One turnaround cycle. Requests are ignored here so the requester can drop or change its request; then go to IDLE.
- When not driven, all outputs are 0.
- `mem_vld` outside IFILL/DFILL is ignored.
- `mem_vld` is never sampled in the same cycle as the grant.
- Counter wrap: `rcv` is 3 bits and is cleared on every grant. `iss` saturates at 8.
- Any change of `i_req`, `d_req` or the addresses during a transaction has no effect; the latched values are used.

## Timing
- Reset: `rst`=0 at an edge forces IDLE, `iss`=`rcv`=0, `last_grant`=I. All outputs are 0 the following cycle, including mid-fill. In-flight memory responses arriving after reset are ignored.
- Request seen in IDLE at cycle T-1 → granted state at T.
- Fill timing with latency L:
  - `mem_en` high T..T+7.
  - `mem_vld` at T+L..T+L+7.
  - `fill_*_we` at T+L..T+L+7.
  - `*_tag_we` and `*_done` at T+L+7.
  - RELEASE at T+L+8; IDLE at T+L+9.
- Write-through: `mem_en`, `mem_wr` and `d_done` at T; RELEASE at T+1; IDLE at T+2.
- Request → `done` latency: fill L+8 cycles, write 1 cycle.
- The earliest next grant is 2 cycles after `done` (sampled at the IDLE cycle).

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with `i_req`=1 → all outputs 0, `busy`=0, no `mem_en`.
- **I-fill:** `i_req`=1, `i_addr`=16'h1236, L=4.
  - → `mem_addr` 16'h1230, 16'h1232 … 16'h123E on 8 consecutive cycles.
  - → `fill_i_we` with `fill_word` 0..7 carrying the memory model's data.
  - → `i_tag_we` and `i_done` together, 11 cycles after the grant cycle's start (T+L+7).
- **Write-through:** `d_req`=1, `d_wr`=1, `d_addr`=16'h0A0C, `d_wdata`=16'hBEEF → one cycle with `mem_en`=`mem_wr`=1, addr 16'h0A0C, data 16'hBEEF, and `d_done`; `busy` low 2 cycles later.
- **Tie alternation:** `i_req` and `d_req` (fill) both held continuously.
  - → first grant D, then I, then D.
  - → each separated by exactly one RELEASE and one IDLE cycle.
- **Reset mid-fill:** `rst`=0 after the 3rd `mem_vld` of a D-fill.
  - → no further `fill_d_we`, no `d_tag_we`.
  - → remaining `mem_vld` pulses are ignored.
  - → a new `i_req` after reset is serviced normally.
- **Variable latency:** memory model with L=1 and L=7, and one-cycle gaps inserted in `mem_vld` → exactly 8 `fill_*_we` with words in order 0..7; `done` coincides with the 8th `mem_vld`.
